// File: rtl/mux_rr_arb_pkg.sv
// Shared definitions for the arbitrated output multiplexer.
// Holds the arbitration-mode constants (ARB_FIXED, ARB_RR) and the ceil-log2
// helper that sizes channel indices.
package mux_rr_arb_pkg;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Returns ceil(log2(n)) for n >= 2, so n channels fit in the result's width.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/mux_rr_arb_if.sv
// Handshake bundle between N producers, the arbiter/mux and one consumer.
//   in_valid  [N]      producer requests
//   in_data   [N*W]    channel i at bits [i*W +: W]
//   in_ready  [N]      per-channel accept, at most one bit high
//   out_valid          output register holds a word
//   out_data  [W]      registered selected word
//   out_sel   [SEL_W]  channel that supplied out_data
//   out_ready          consumer accepts out_data
// master: traffic source/sink side; slave: the mux block.
interface mux_rr_arb_if
   import mux_rr_arb_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 16
);
   localparam int SEL_W = clog2(N);

   logic [N-1:0]     in_valid;
   logic [N*W-1:0]   in_data;
   logic [N-1:0]     in_ready;
   logic             out_valid;
   logic [W-1:0]     out_data;
   logic [SEL_W-1:0] out_sel;
   logic             out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );

endinterface

// File: rtl/mux_rr_arb_arbiter.sv
// Combinational arbiter: rotate the request vector so ptr sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back by ptr.
//   req       [N]      requests
//   ptr       [SEL_W]  highest-priority channel (ignored for fixed priority)
//   grant     [N]      one-hot grant, all zero when nothing requests
//   grant_idx [SEL_W]  index of the granted channel (0 when no grant)
module rr_arbiter
   import mux_rr_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int RR = ARB_RR,
   localparam int SEL_W = clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [SEL_W-1:0] grant_idx
);

   logic [SEL_W-1:0] eff_ptr;
   logic [2*N-1:0]   req_shift;
   logic [N-1:0]     req_rot;
   logic [SEL_W-1:0] idx_rot;
   logic [SEL_W:0]   idx_sum;
   logic             found;

   assign eff_ptr = (RR == ARB_RR) ? ptr : '0;

   always_comb begin
      req_shift = {req, req} >> eff_ptr;
      req_rot   = req_shift[N-1:0];
      found     = 1'b0;
      idx_rot   = '0;
      for (int i = 0; i < N; i++) begin
         if (req_rot[i] && !found) begin
            found   = 1'b1;
            idx_rot = SEL_W'(i);
         end
      end
      // Undo the rotation; the sum stays below 2N so one subtraction wraps it.
      idx_sum = {1'b0, idx_rot} + {1'b0, eff_ptr};
      if (idx_sum >= (SEL_W+1)'(N)) idx_sum = idx_sum - (SEL_W+1)'(N);
      grant_idx = found ? idx_sum[SEL_W-1:0] : '0;
      grant     = '0;
      for (int i = 0; i < N; i++) begin
         grant[i] = found && (idx_sum[SEL_W-1:0] == SEL_W'(i));
      end
   end

endmodule

// File: rtl/mux_rr_arb.sv
// N-channel registered multiplexer with fixed-priority or round-robin
// arbitration and valid/ready handshakes on both sides.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mux_rr_arb_if.slave (producer requests/data, consumer handshake)
// The output word, its source index and the round-robin pointer are registers;
// in_ready is combinational from in_valid, ptr, out_valid and out_ready only.
module mux_rr_arb
   import mux_rr_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int W  = 16,
   parameter int RR = ARB_RR,
   localparam int SEL_W = clog2(N)
) (
   input  logic       clk,
   input  logic       rst_n,
   mux_rr_arb_if.slave bus
);

   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     out_data_q,  out_data_d;
   logic [SEL_W-1:0] out_sel_q,   out_sel_d;
   logic [SEL_W-1:0] ptr_q,       ptr_d;

   logic [N-1:0]     grant;
   logic [SEL_W-1:0] grant_idx;
   logic [W-1:0]     sel_data;
   logic             load;
   logic             xfer;

   rr_arbiter #(.N(N), .RR(RR)) u_arb (
      .req       (bus.in_valid),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Output register is empty or being drained this cycle.
   assign load         = ~out_valid_q | bus.out_ready;
   assign bus.in_ready = grant & {N{load}};
   assign xfer         = |(bus.in_valid & bus.in_ready);

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         sel_data = sel_data | (bus.in_data[i*W +: W] & {W{grant[i]}});
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      ptr_d       = ptr_q;
      if (load) begin
         if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_sel_d   = grant_idx;
            if (RR == ARB_RR) begin
               ptr_d = (grant_idx == SEL_W'(N-1)) ? '0 : grant_idx + 1'b1;
            end
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         ptr_q       <= ptr_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;

endmodule
